// File: rtl/mac_pkg.sv
// Shared widths and constants for the MAC datapath multiply stage.
package mac_pkg;

  localparam int unsigned MUL_IN_W  = 8;
  localparam int unsigned MUL_OUT_W = 16;

  // Baugh-Wooley correction for 8x8: ones at bit 8 and bit 15.
  localparam logic [MUL_OUT_W-1:0] BW_CORR = 16'h8100;

  // A partial-product cell is a NAND when exactly one index is the sign bit.
  function automatic logic bw_inverted(input int unsigned i, input int unsigned j);
    return (i == MUL_IN_W - 1) != (j == MUL_IN_W - 1);
  endfunction

endpackage

// File: rtl/bw_full_adder.sv
// 1-bit full adder cell used throughout the multiplier array and final row.
module bw_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/baugh_wooley_mult8_reg.sv
// 8x8 signed Baugh-Wooley array multiplier with a single registered output.
module baugh_wooley_mult8_reg
  import mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [MUL_IN_W-1:0]  a,
  input  logic [MUL_IN_W-1:0]  b,
  output logic                 out_valid,
  output logic [MUL_OUT_W-1:0] out
);

  localparam int unsigned NR = MUL_IN_W;
  localparam int unsigned W  = MUL_OUT_W;

  logic [NR-1:0][W-1:0] row;
  logic [NR:0][W-1:0]   s_v;
  logic [NR:0][W-1:0]   c_v;
  logic [W-1:0]         ripple_c;
  logic [W-1:0]         prod_c;

  // Partial-product rows, each aligned to its b-bit weight.
  for (genvar i = 0; i < NR; i++) begin : g_row
    for (genvar k = 0; k < W; k++) begin : g_col
      if ((k >= i) && ((k - i) < NR)) begin : g_pp
        localparam int unsigned J = k - i;
        if (bw_inverted(i, J)) begin : g_nand
          assign row[i][k] = ~(a[J] & b[i]);
        end else begin : g_and
          assign row[i][k] = a[J] & b[i];
        end
      end else begin : g_zero
        assign row[i][k] = 1'b0;
      end
    end
  end

  // Carry-save accumulation seeded with the correction constant.
  assign s_v[0] = BW_CORR;
  assign c_v[0] = '0;

  for (genvar i = 0; i < NR; i++) begin : g_csa
    assign c_v[i+1][0] = 1'b0;
    for (genvar k = 0; k < W - 1; k++) begin : g_bit
      bw_full_adder u_fa (
        .a    (s_v[i][k]),
        .b    (c_v[i][k]),
        .cin  (row[i][k]),
        .sum  (s_v[i+1][k]),
        .cout (c_v[i+1][k+1])
      );
    end
    // Top column: carry out of bit 15 is discarded, so only the sum is formed.
    assign s_v[i+1][W-1] = s_v[i][W-1] ^ c_v[i][W-1] ^ row[i][W-1];
  end

  // Final ripple carry-propagate row.
  assign ripple_c[0] = 1'b0;
  for (genvar k = 0; k < W - 1; k++) begin : g_cpa
    bw_full_adder u_fa (
      .a    (s_v[NR][k]),
      .b    (c_v[NR][k]),
      .cin  (ripple_c[k]),
      .sum  (prod_c[k]),
      .cout (ripple_c[k+1])
    );
  end
  assign prod_c[W-1] = s_v[NR][W-1] ^ c_v[NR][W-1] ^ ripple_c[W-1];

  // Output register: product loads only on valid, valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= prod_c;
      end
    end
  end

endmodule

// File: tb/tb_baugh_wooley_mult8_reg.sv
// Self-checking bench for baugh_wooley_mult8_reg: vectors, streaming, reset, exhaustive.
module tb_baugh_wooley_mult8_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [15:0] out;

  int tests_run;
  int tests_failed;

  logic [15:0] sb_q[$];
  logic [15:0] exp_out;
  logic        exp_valid;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[10];

  baugh_wooley_mult8_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h (a=%h b=%h t=%0t)", name, act, req, a, b, $time);
    end
  endtask

  // Drive at the negedge, sample 1 time unit after the next posedge.
  task automatic cycle(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] prod);
    in_valid = v;
    a        = aa;
    b        = bb;
    if (v) sb_q.push_back(prod);
    exp_valid = v;
    @(posedge clk);
    #1;
    check("out_valid", 16'(out_valid), 16'(exp_valid));
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 16'h1, 16'h0);
      end else begin
        exp_out = sb_q.pop_front();
        check("product", out, exp_out);
      end
    end else begin
      check("out_hold", out, exp_out);
    end
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_out      = 16'h0000;
    exp_valid    = 1'b0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    a            = 8'h00;
    b            = 8'h00;

    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'hFD, 8'h03, 16'hFFF7};
    vecs[2] = '{8'h08, 8'hF8, 16'hFFC0};
    vecs[3] = '{8'hFB, 8'hFE, 16'h000A};
    vecs[4] = '{8'h80, 8'h01, 16'hFF80};
    vecs[5] = '{8'h7F, 8'h02, 16'h00FE};
    vecs[6] = '{8'h80, 8'h80, 16'h4000};
    vecs[7] = '{8'h7F, 8'h80, 16'hC080};
    vecs[8] = '{8'h00, 8'h00, 16'h0000};
    vecs[9] = '{8'h00, 8'hFF, 16'h0000};

    // Reset state
    #12;
    check("reset_out", out, 16'h0000);
    check("reset_valid", 16'(out_valid), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic products and extremes, each followed by an idle cycle
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].prod);
      cycle(1'b0, 8'h00, 8'h00, 16'h0000);
    end

    // Streaming back-to-back, then drop valid and expect hold of -64
    cycle(1'b1, 8'h03, 8'h05, 16'h000F);
    cycle(1'b1, 8'hFD, 8'h03, 16'hFFF7);
    cycle(1'b1, 8'h08, 8'hF8, 16'hFFC0);
    cycle(1'b0, 8'h5A, 8'hA5, 16'h0000);
    check("stream_hold", out, 16'hFFC0);

    // Asynchronous reset while holding a valid product
    cycle(1'b1, 8'h03, 8'h05, 16'h000F);
    in_valid = 1'b0;
    check("pre_reset_out", out, 16'h000F);
    check("pre_reset_valid", 16'(out_valid), 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out", out, 16'h0000);
    check("async_reset_valid", 16'(out_valid), 16'h0000);
    sb_q.delete();
    exp_out = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 8'hxx, 8'hxx, 16'h0000);
    cycle(1'b0, 8'h7F, 8'h7F, 16'h0000);
    check("post_reset_out", out, 16'h0000);

    // Exhaustive sweep of all operand pairs
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        logic [7:0] av;
        logic [7:0] bv;
        int         p;
        av = 8'(ai);
        bv = 8'(bi);
        p  = int'($signed(av)) * int'($signed(bv));
        cycle(1'b1, av, bv, p[15:0]);
      end
    end
    cycle(1'b0, 8'h00, 8'h00, 16'h0000);
    check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/baugh_wooley_mult8_reg.md
Name: baugh_wooley_mult8_reg

Overview:
8x8 two's-complement signed multiplier built as a Baugh-Wooley partial-product array, producing a full 16-bit signed product. The combinational array feeds a single output register, so the product appears one clock after operands are sampled. It serves as the multiply stage of the MAC datapath, ahead of the accumulator.

Parameters:
None. Width is fixed at 8x8 -> 16. The Baugh-Wooley correction constants are specific to this width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  a/b hold a valid operand pair this cycle
a  input  8  multiplicand, signed two's complement
b  input  8  multiplier, signed two's complement
out_valid  output  1  out holds the product of the pair sampled on the previous valid edge
out  output  16  signed two's-complement product a*b

Behaviour:
- Reset: rst high asynchronously forces out=16'h0000 and out_valid=0, independent of clk. Both hold until the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle.
  - On a rising clk edge with rst low: out_valid <= in_valid.
  - If in_valid=1, out <= a*b at the same edge.
  - If in_valid=0, out holds its previous value; only out_valid drops.
- Throughput: one product per cycle. Back-to-back valid inputs produce back-to-back valid outputs. There is no stall or backpressure.
- Partial products, for i (b index) and j (a index) in 0..7:
  - pp[i][j] = a[j] & b[i] when i<7 and j<7, or when i=7 and j=7.
  - pp[i][j] = ~(a[j] & b[i]) when exactly one of i, j is 7.
  - pp[i][j] has weight 2^(i+j).
- Correction: add a constant 1 at bit 8 and a constant 1 at bit 15.
- Summation:
  - Sum all partial products plus the correction with a carry-save array of full/half adders, followed by a final ripple carry-propagate row.
  - Keep only bits [15:0]. Discard any carry out of bit 15.
  - The result must equal the exact signed product for all 65536 operand pairs.
- Range: the product lies in -16256..+16384.
  - -128*-128 = +16384 (16'h4000) is representable and must be correct.
  - There is no overflow or saturation case.
- Operator restriction: the array is built from explicit bit-level AND/NAND cells and adder cells. A behavioural "*" operator is not used in RTL; it may appear only in the bench model.
- X handling: X on a or b while in_valid=0 must not corrupt out, because out does not load.
- Reset mid-stream: a pair sampled on the edge before rst asserts is lost. out_valid is 0 after reset until a new valid pair is sampled.

Decomposition:
- Package mac_pkg holds:
  - MUL_IN_W=8, MUL_OUT_W=16.
  - The Baugh-Wooley correction constant 16'h8100 (bits 15 and 8).
- Sub-module bw_full_adder: 1-bit full adder (a, b, cin -> sum, cout).
  - It is instantiated throughout the array and the final carry-propagate row.
  - A half adder is a full adder with cin tied to 0.
- The top level generates the partial-product matrix and the adder array, and holds the output register.

Test Plan:
1. Basic products, each followed by one idle cycle:
   - a=3, b=5 -> out=16'h000F (15).
   - a=-3 (8'hFD), b=3 -> out=16'hFFF7 (-9).
   - a=8, b=-8 (8'hF8) -> out=16'hFFC0 (-64).
   - a=-5 (8'hFB), b=-2 (8'hFE) -> out=16'h000A (10).
   - In each case out_valid=1 exactly one cycle after in_valid.
2. Extremes:
   - -128*1 -> 16'hFF80.
   - 127*2 -> 16'h00FE (254).
   - -128*-128 -> 16'h4000.
   - 127*-128 -> 16'hC080 (-16256).
   - 0*0 -> 0.
   - 0*-1 (8'hFF) -> 0.
3. Streaming: valid pairs (3,5), (-3,3), (8,-8) on consecutive cycles -> out = 15, -9, -64 on the 3 following cycles with out_valid held at 1. Drop in_valid -> out_valid=0 and out holds -64.
4. Reset: assert rst asynchronously between clk edges while out=16'h000F, out_valid=1 -> both clear immediately. After release with in_valid=0, they stay 0.
5. Exhaustive: all 65536 (a,b) pairs -> out == $signed(a)*$signed(b), checked one cycle later with zero mismatches.
